// File: rtl/lowx_mem_arbiter_pkg.sv
// Shared types and defaults for the lowX memory arbiter that multiplexes
// icache and dcache block traffic onto one main-memory port.
package lowx_mem_arbiter_pkg;

  typedef enum logic [1:0] {ARB_IDLE, ARB_REQ, ARB_WAIT, ARB_RESP} arb_state_e;
  typedef enum logic {ARB_IC, ARB_DC} arb_owner_e;

  localparam int ARB_XLEN    = 32;
  localparam int ARB_BLK     = 128;
  localparam int ARB_TIMEOUT = 1024;

  // Other requester of the 2-way round-robin pair.
  function automatic arb_owner_e arb_other(input arb_owner_e owner);
    return (owner == ARB_IC) ? ARB_DC : ARB_IC;
  endfunction

endpackage

// File: rtl/lowx_mem_arbiter.sv
// Round-robin arbiter giving the icache and dcache lowX interfaces one shared
// memory port, one transaction at a time, with a watchdog on the memory response.
module lowx_mem_arbiter
  import lowx_mem_arbiter_pkg::*;
#(
  parameter int XLEN        = ARB_XLEN,
  parameter int BLK_SIZE    = ARB_BLK,
  parameter int TIMEOUT_CYC = ARB_TIMEOUT
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                ic_req_valid_i,
  input  logic [XLEN-1:0]     ic_req_addr_i,
  output logic                ic_res_valid_o,
  output logic [BLK_SIZE-1:0] ic_res_blk_o,
  input  logic                dc_req_valid_i,
  input  logic [XLEN-1:0]     dc_req_addr_i,
  input  logic                dc_req_rw_i,
  input  logic [BLK_SIZE-1:0] dc_req_data_i,
  output logic                dc_res_valid_o,
  output logic [BLK_SIZE-1:0] dc_res_blk_o,
  output logic                res_err_o,
  output logic                mem_req_valid_o,
  input  logic                mem_req_ready_i,
  output logic [XLEN-1:0]     mem_req_addr_o,
  output logic                mem_req_rw_o,
  output logic [BLK_SIZE-1:0] mem_req_data_o,
  input  logic                mem_res_valid_i,
  input  logic [BLK_SIZE-1:0] mem_res_data_i
);

  // A zero timeout still needs a legal one-bit counter.
  localparam int CW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYC - 1);
  localparam bit            TMO_EN   = (TIMEOUT_CYC != 0);

  arb_state_e    state_r;
  arb_owner_e    owner_r;
  arb_owner_e    last_grant_r;
  logic [CW-1:0] cnt_r;

  logic          grant_s;
  arb_owner_e    pick_s;
  logic          timeout_s;
  logic [CW-1:0] cnt_next_s;
  logic [BLK_SIZE-1:0] res_blk_s;

  // Round-robin pick between the two requesters.
  always_comb begin
    grant_s = ic_req_valid_i | dc_req_valid_i;
    pick_s  = ARB_IC;
    if (ic_req_valid_i && dc_req_valid_i) begin
      pick_s = arb_other(last_grant_r);
    end else if (dc_req_valid_i) begin
      pick_s = ARB_DC;
    end else begin
      pick_s = ARB_IC;
    end
  end

  // Watchdog compare, saturating counter step and write-filtered response data.
  always_comb begin
    timeout_s  = TMO_EN && (cnt_r == TMO_LAST);
    cnt_next_s = (cnt_r == CNT_MAX) ? cnt_r : cnt_r + CW'(1);
    if (mem_req_rw_o) begin
      res_blk_s = {BLK_SIZE{1'b0}};
    end else begin
      res_blk_s = mem_res_data_i;
    end
  end

  // Transaction FSM; every output is a register written here.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r         <= ARB_IDLE;
      owner_r         <= ARB_IC;
      last_grant_r    <= ARB_IC;
      cnt_r           <= {CW{1'b0}};
      ic_res_valid_o  <= 1'b0;
      ic_res_blk_o    <= {BLK_SIZE{1'b0}};
      dc_res_valid_o  <= 1'b0;
      dc_res_blk_o    <= {BLK_SIZE{1'b0}};
      res_err_o       <= 1'b0;
      mem_req_valid_o <= 1'b0;
      mem_req_addr_o  <= {XLEN{1'b0}};
      mem_req_rw_o    <= 1'b0;
      mem_req_data_o  <= {BLK_SIZE{1'b0}};
    end else begin
      case (state_r)
        ARB_IDLE: begin
          if (grant_s) begin
            owner_r         <= pick_s;
            last_grant_r    <= pick_s;
            mem_req_valid_o <= 1'b1;
            if (pick_s == ARB_DC) begin
              mem_req_addr_o <= dc_req_addr_i;
              mem_req_rw_o   <= dc_req_rw_i;
              mem_req_data_o <= dc_req_data_i;
            end else begin
              mem_req_addr_o <= ic_req_addr_i;
              mem_req_rw_o   <= 1'b0;
              mem_req_data_o <= {BLK_SIZE{1'b0}};
            end
            state_r <= ARB_REQ;
          end else begin
            state_r <= ARB_IDLE;
          end
        end
        ARB_REQ: begin
          if (mem_req_ready_i) begin
            mem_req_valid_o <= 1'b0;
            cnt_r           <= {CW{1'b0}};
            state_r         <= ARB_WAIT;
          end else begin
            state_r <= ARB_REQ;
          end
        end
        ARB_WAIT: begin
          cnt_r <= cnt_next_s;
          // A response arriving on the timeout cycle takes priority.
          if (mem_res_valid_i || timeout_s) begin
            res_err_o <= ~mem_res_valid_i;
            if (owner_r == ARB_DC) begin
              dc_res_valid_o <= 1'b1;
              dc_res_blk_o   <= mem_res_valid_i ? res_blk_s : {BLK_SIZE{1'b0}};
            end else begin
              ic_res_valid_o <= 1'b1;
              ic_res_blk_o   <= mem_res_valid_i ? res_blk_s : {BLK_SIZE{1'b0}};
            end
            state_r <= ARB_RESP;
          end else begin
            state_r <= ARB_WAIT;
          end
        end
        ARB_RESP: begin
          ic_res_valid_o <= 1'b0;
          ic_res_blk_o   <= {BLK_SIZE{1'b0}};
          dc_res_valid_o <= 1'b0;
          dc_res_blk_o   <= {BLK_SIZE{1'b0}};
          res_err_o      <= 1'b0;
          state_r        <= ARB_IDLE;
        end
        default: begin
          state_r <= ARB_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lowx_mem_arbiter.sv
// Directed scoreboard bench for lowx_mem_arbiter with a 16-cycle watchdog.
module tb_lowx_mem_arbiter;

  localparam int XLEN = 32;
  localparam int BLK  = 128;
  localparam int TMO  = 16;

  logic             clk = 1'b0;
  logic             rst_i;
  logic             ic_req_valid_i;
  logic [XLEN-1:0]  ic_req_addr_i;
  logic             ic_res_valid_o;
  logic [BLK-1:0]   ic_res_blk_o;
  logic             dc_req_valid_i;
  logic [XLEN-1:0]  dc_req_addr_i;
  logic             dc_req_rw_i;
  logic [BLK-1:0]   dc_req_data_i;
  logic             dc_res_valid_o;
  logic [BLK-1:0]   dc_res_blk_o;
  logic             res_err_o;
  logic             mem_req_valid_o;
  logic             mem_req_ready_i;
  logic [XLEN-1:0]  mem_req_addr_o;
  logic             mem_req_rw_o;
  logic [BLK-1:0]   mem_req_data_o;
  logic             mem_res_valid_i;
  logic [BLK-1:0]   mem_res_data_i;

  always #5 clk = ~clk;

  lowx_mem_arbiter #(.XLEN(XLEN), .BLK_SIZE(BLK), .TIMEOUT_CYC(TMO)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .ic_req_valid_i(ic_req_valid_i), .ic_req_addr_i(ic_req_addr_i),
    .ic_res_valid_o(ic_res_valid_o), .ic_res_blk_o(ic_res_blk_o),
    .dc_req_valid_i(dc_req_valid_i), .dc_req_addr_i(dc_req_addr_i),
    .dc_req_rw_i(dc_req_rw_i), .dc_req_data_i(dc_req_data_i),
    .dc_res_valid_o(dc_res_valid_o), .dc_res_blk_o(dc_res_blk_o),
    .res_err_o(res_err_o),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
    .mem_req_addr_o(mem_req_addr_o), .mem_req_rw_o(mem_req_rw_o),
    .mem_req_data_o(mem_req_data_o),
    .mem_res_valid_i(mem_res_valid_i), .mem_res_data_i(mem_res_data_i)
  );

  typedef struct {
    logic            dc;
    logic [XLEN-1:0] addr;
    logic            rw;
    logic [BLK-1:0]  wdata;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [BLK-1:0] obs, input logic [BLK-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Serve the next scoreboard entry as the memory; respond=0 lets the watchdog fire.
  task automatic run_txn(input int rdy_dly, input int resp_dly,
                         input logic [BLK-1:0] rdata, input bit respond);
    exp_t           e;
    int             n;
    logic [BLK-1:0] eblk;
    logic           eerr;
    n = 0;
    do begin
      tick();
      n++;
    end while (!mem_req_valid_o && n < 20);
    chki("req_latency", n, 1);
    e = sb.pop_front();
    chk("req_addr", BLK'(mem_req_addr_o), BLK'(e.addr));
    chk1("req_rw", mem_req_rw_o, e.rw);
    chk("req_data", mem_req_data_o, e.wdata);
    for (int i = 0; i < rdy_dly; i++) begin
      ic_req_addr_i = $urandom;
      dc_req_addr_i = $urandom;
      dc_req_data_i = {4{$urandom}};
      tick();
      chk1("hold_valid", mem_req_valid_o, 1'b1);
      chk("hold_addr", BLK'(mem_req_addr_o), BLK'(e.addr));
      chk1("hold_rw", mem_req_rw_o, e.rw);
      chk("hold_data", mem_req_data_o, e.wdata);
    end
    mem_req_ready_i = 1'b1;
    tick();
    mem_req_ready_i = 1'b0;
    chk1("hs_drop", mem_req_valid_o, 1'b0);
    n = 0;
    if (respond) begin
      repeat (resp_dly) begin
        tick();
        chk1("no_early_pulse", ic_res_valid_o | dc_res_valid_o, 1'b0);
      end
      mem_res_valid_i = 1'b1;
      mem_res_data_i  = rdata;
      tick();
      mem_res_valid_i = 1'b0;
      mem_res_data_i  = {4{$urandom}};
    end else begin
      while (!(ic_res_valid_o | dc_res_valid_o) && n < 100) begin
        tick();
        n++;
      end
      chki("timeout_latency", n, TMO);
    end
    eblk = (respond && !e.rw) ? rdata : {BLK{1'b0}};
    eerr = !respond;
    chk1("ic_pulse", ic_res_valid_o, !e.dc);
    chk1("dc_pulse", dc_res_valid_o, e.dc);
    chk("res_blk", e.dc ? dc_res_blk_o : ic_res_blk_o, eblk);
    chk1("res_err", res_err_o, eerr);
    if (e.dc) dc_req_valid_i = 1'b0;
    else      ic_req_valid_i = 1'b0;
    tick();
    chk1("pulse_end", ic_res_valid_o | dc_res_valid_o, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    rst_i = 1'b1;
    ic_req_valid_i = 1'b0; ic_req_addr_i = '0;
    dc_req_valid_i = 1'b0; dc_req_addr_i = '0; dc_req_rw_i = 1'b0; dc_req_data_i = '0;
    mem_req_ready_i = 1'b0; mem_res_valid_i = 1'b0; mem_res_data_i = '0;
    tick();
    tick();
    chk1("rst_mem_valid", mem_req_valid_o, 1'b0);
    chk1("rst_ic_valid", ic_res_valid_o, 1'b0);
    chk1("rst_dc_valid", dc_res_valid_o, 1'b0);
    chk1("rst_err", res_err_o, 1'b0);
    chk("rst_addr", BLK'(mem_req_addr_o), '0);
    rst_i = 1'b0;
    tick();

    // Lone icache refill, response in the third WAIT cycle.
    ic_req_valid_i = 1'b1; ic_req_addr_i = 32'h8000_0040;
    sb.push_back('{1'b0, 32'h8000_0040, 1'b0, {BLK{1'b0}}});
    run_txn(0, 2, 128'hDEAD_1111_2222_3333_4444_5555_6666_BEEF, 1'b1);

    // Simultaneous requests twice: DC, IC, DC, IC.
    for (int r = 0; r < 2; r++) begin
      ic_req_valid_i = 1'b1; ic_req_addr_i = 32'h0000_1000 + 32'(r);
      dc_req_valid_i = 1'b1; dc_req_addr_i = 32'h0000_2000 + 32'(r); dc_req_rw_i = 1'b0;
      dc_req_data_i = 128'h5555_AAAA;
      sb.push_back('{1'b1, 32'h0000_2000 + 32'(r), 1'b0, 128'h5555_AAAA});
      sb.push_back('{1'b0, 32'h0000_1000 + 32'(r), 1'b0, {BLK{1'b0}}});
      run_txn(0, 0, 128'hD0D0_0000 + 128'(r), 1'b1);
      run_txn(0, 1, 128'h1C1C_0000 + 128'(r), 1'b1);
    end

    // Writeback with a slow memory accept; blk must read back as zero.
    dc_req_valid_i = 1'b1; dc_req_addr_i = 32'h4000_0100; dc_req_rw_i = 1'b1;
    dc_req_data_i = 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321;
    sb.push_back('{1'b1, 32'h4000_0100, 1'b1, 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321});
    run_txn(5, 1, 128'hFFFF_EEEE_DDDD_CCCC, 1'b1);
    dc_req_rw_i = 1'b0;

    // Memory never answers: watchdog error.
    ic_req_valid_i = 1'b1; ic_req_addr_i = 32'h8000_0080;
    sb.push_back('{1'b0, 32'h8000_0080, 1'b0, {BLK{1'b0}}});
    run_txn(0, 0, '0, 1'b0);

    // Response on the final watchdog cycle wins.
    dc_req_valid_i = 1'b1; dc_req_addr_i = 32'h4000_0200;
    dc_req_data_i = '0;
    sb.push_back('{1'b1, 32'h4000_0200, 1'b0, {BLK{1'b0}}});
    run_txn(0, TMO - 1, 128'hCAFE_F00D_0000_0001, 1'b1);

    // Reset during WAIT, then a stray late response.
    ic_req_valid_i = 1'b1; ic_req_addr_i = 32'h8000_00C0;
    tick();
    chk1("pre_rst_req", mem_req_valid_o, 1'b1);
    mem_req_ready_i = 1'b1;
    tick();
    mem_req_ready_i = 1'b0;
    tick();
    tick();
    #2 rst_i = 1'b1;
    ic_req_valid_i = 1'b0;
    #1;
    chk("async_rst_addr", BLK'(mem_req_addr_o), '0);
    chk1("async_rst_valid", mem_req_valid_o, 1'b0);
    tick();
    rst_i = 1'b0;
    mem_res_valid_i = 1'b1; mem_res_data_i = 128'hBAD0_BAD0;
    tick();
    mem_res_valid_i = 1'b0;
    tick();
    chk1("stray_ic", ic_res_valid_o, 1'b0);
    chk1("stray_dc", dc_res_valid_o, 1'b0);
    chk1("stray_req", mem_req_valid_o, 1'b0);

    // Contention right after reset again favours the dcache.
    ic_req_valid_i = 1'b1; ic_req_addr_i = 32'h8000_0100;
    dc_req_valid_i = 1'b1; dc_req_addr_i = 32'h4000_0300;
    sb.push_back('{1'b1, 32'h4000_0300, 1'b0, {BLK{1'b0}}});
    sb.push_back('{1'b0, 32'h8000_0100, 1'b0, {BLK{1'b0}}});
    run_txn(0, 0, 128'h0123_4567, 1'b1);
    run_txn(1, 3, 128'h89AB_CDEF, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
